// File: rtl/divisor_seq.sv
`default_nettype none
// ============================================================================
// Module      : divisor_seq
// Description : Sequential restoring divider, unsigned N/N bits, one quotient
//               bit per two clocks, St/Idle/Done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         St,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Idle,
    output logic         Done,
    output logic         DivZero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SUB   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic [N:0]     r_rem;
    logic [N-1:0]   r_quo;
    logic [N-1:0]   r_div;
    logic [CW-1:0]  r_cnt;
    logic           r_idle;
    logic           r_done;
    logic           r_divzero;
    logic [N:0]     w_trial;

    // Trial subtraction at N+1 bits; MSB set means the divisor did not fit.
    assign w_trial = r_rem - {1'b0, r_div};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_idle    <= 1'b1;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (St) begin
                        r_idle <= 1'b0;
                        if (Divisor == '0) begin
                            r_divzero <= 1'b1;
                            r_quo     <= '1;
                            r_rem     <= {1'b0, Dividend};
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_divzero <= 1'b0;
                            r_rem     <= '0;
                            r_quo     <= Dividend;
                            r_div     <= Divisor;
                            r_cnt     <= CW'(N);
                            r_state   <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    {r_rem, r_quo} <= {r_rem[N-1:0], r_quo, 1'b0};
                    r_state        <= S_SUB;
                end
                S_SUB: begin
                    if (!w_trial[N]) begin
                        r_rem    <= w_trial;
                        r_quo[0] <= 1'b1;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Quotient  = r_quo;
    assign Remainder = r_rem[N-1:0];
    assign Idle      = r_idle;
    assign Done      = r_done;
    assign DivZero   = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_divisor_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor_seq
// Description : Self-checking bench for divisor_seq (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_seq;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int DIV_EDGES = 2 * N + 1;

    logic         Clk;
    logic         Reset;
    logic         St;
    logic [N-1:0] Dividend;
    logic [N-1:0] Divisor;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         Idle;
    logic         Done;
    logic         DivZero;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    divisor_seq #(.N(N), .CW(CW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .St        (St),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Idle      (Idle),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        edge_cnt++;
    endtask

    // Pulse St for one edge, then scramble the operand inputs.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        St       = 1'b1;
        Dividend = a;
        Divisor  = b;
        edge_cnt = 0;
        step();
        St       = 1'b0;
        Dividend = N'($urandom);
        Divisor  = N'($urandom);
    endtask

    // Reference: plain integer division, or the divide-by-zero convention.
    task automatic wait_done(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        int exp_q, exp_r, exp_e;
        if (b == 0) begin
            exp_q = (1 << N) - 1;
            exp_r = int'(a);
            exp_e = 1;
        end else begin
            exp_q = int'(a) / int'(b);
            exp_r = int'(a) % int'(b);
            exp_e = DIV_EDGES;
        end
        while (!Done && edge_cnt < 40) step();
        check({tag, ".done"},    32'(Done), 32'd1);
        check({tag, ".latency"}, 32'(edge_cnt), 32'(exp_e));
        check({tag, ".q"},       32'(Quotient), 32'(exp_q));
        check({tag, ".r"},       32'(Remainder), 32'(exp_r));
        check({tag, ".dz"},      32'(DivZero), 32'(b == 0));
        if (b != 0) begin
            check({tag, ".inv"}, 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
            check({tag, ".rltd"}, 32'(Remainder < b), 32'd1);
        end
        step();
        check({tag, ".done_off"}, 32'(Done), 32'd0);
        check({tag, ".idle"},     32'(Idle), 32'd1);
        check({tag, ".q_hold"},   32'(Quotient), 32'(exp_q));
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        int first_done;

        Reset    = 1'b1;
        St       = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        step();
        step();
        check("rst.idle", 32'(Idle), 32'd1);
        check("rst.done", 32'(Done), 32'd0);
        check("rst.dz",   32'(DivZero), 32'd0);
        check("rst.q",    32'(Quotient), 32'd0);
        check("rst.r",    32'(Remainder), 32'd0);
        Reset = 1'b0;
        step();
        check("idle.hold", 32'(Idle), 32'd1);

        // Directed cases.
        start_op(8'd100, 8'd7);  wait_done("d100_7",  8'd100, 8'd7);
        start_op(8'd255, 8'd1);  wait_done("d255_1",  8'd255, 8'd1);
        start_op(8'd5,   8'd9);  wait_done("d5_9",    8'd5,   8'd9);
        start_op(8'd0,   8'd3);  wait_done("d0_3",    8'd0,   8'd3);
        start_op(8'd255, 8'd255); wait_done("d255_255", 8'd255, 8'd255);
        start_op(8'd42,  8'd0);  wait_done("d42_0",   8'd42,  8'd0);
        start_op(8'd10,  8'd3);  wait_done("d10_3",   8'd10,  8'd3);

        // Asynchronous reset in the middle of a division.
        start_op(8'd200, 8'd3);
        repeat (5) step();
        Reset = 1'b1;
        #1;
        check("mid_rst.idle", 32'(Idle), 32'd1);
        check("mid_rst.done", 32'(Done), 32'd0);
        check("mid_rst.q",    32'(Quotient), 32'd0);
        check("mid_rst.r",    32'(Remainder), 32'd0);
        step();
        Reset = 1'b0;
        step();
        check("post_rst.idle", 32'(Idle), 32'd1);
        start_op(8'd200, 8'd3);  wait_done("d200_3",  8'd200, 8'd3);

        // St pulsed while busy must not disturb the running division.
        start_op(8'd100, 8'd7);
        step();
        step();
        St = 1'b1; Dividend = 8'd13; Divisor = 8'd2;
        step();
        St = 1'b0;
        step();
        St = 1'b1; Dividend = 8'd77; Divisor = 8'd0;
        step();
        St = 1'b0;
        wait_done("busy_st", 8'd100, 8'd7);

        // St held high: back-to-back operations, operands switched while busy.
        St = 1'b1; Dividend = 8'd50; Divisor = 8'd6;
        edge_cnt = 0;
        step();
        Dividend = 8'd9; Divisor = 8'd4;
        while (!Done && edge_cnt < 40) step();
        first_done = edge_cnt;
        check("b2b1.done", 32'(Done), 32'd1);
        check("b2b1.q",    32'(Quotient), 32'd8);
        check("b2b1.r",    32'(Remainder), 32'd2);
        step();
        check("b2b1.done_off", 32'(Done), 32'd0);
        check("b2b1.idle",     32'(Idle), 32'd1);
        while (!Done && edge_cnt < 80) step();
        St = 1'b0;
        check("b2b2.done", 32'(Done), 32'd1);
        check("b2b2.gap",  32'(edge_cnt - first_done), 32'd18);
        check("b2b2.q",    32'(Quotient), 32'd2);
        check("b2b2.r",    32'(Remainder), 32'd1);
        step();
        check("b2b2.done_off", 32'(Done), 32'd0);
        step();
        check("b2b2.no_restart", 32'(Idle), 32'd1);

        // Random regression, roughly one in eight divisors zero.
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            start_op(a, b);
            wait_done("rand", a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Sequential restoring divider; the shift-subtract counterpart of the team's shift-add multiplier.
- Performs unsigned N-bit by N-bit division, one quotient bit per two clocks.
- Contains its own datapath registers and a Moore control FSM, with an St/Idle/Done handshake matching the multiplier block.
- Sits beside the multiplier in the MIPS_CPU arithmetic unit, where it serves DIV/DIVU-style operations.

Parameters:
- N, 8, operand width; also the quotient, remainder and iteration count.
- CW, 4, iteration counter width; must satisfy 2^CW > N.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; forces the IDLE state and clears all registers.
- St  input  1  start request; sampled only in IDLE.
- Dividend  input  N  unsigned dividend; captured on the start edge.
- Divisor  input  N  unsigned divisor; captured on the start edge.
- Quotient  output  N  registered quotient; valid from Done until the next start.
- Remainder  output  N  registered remainder; valid from Done until the next start.
- Idle  output  1  high while in IDLE; ready for St.
- Done  output  1  one-cycle completion pulse (Moore, from state DONE).
- DivZero  output  1  registered flag; set when the captured divisor is 0, cleared on the next start.

Behaviour:
- Reset values: state=IDLE, Idle=1, Done=0, DivZero=0, Quotient=0, Remainder=0, internal R/Q/D/count=0.
- Reset is asynchronous and wins at any time, including mid-division. The partial result is discarded and the FSM is in IDLE on the next cycle.
- Internal registers: R (N+1 bits, partial remainder), Q (N bits, dividend→quotient), D (N bits), cnt (CW bits).
- FSM has four states: IDLE, SHIFT, SUB, DONE. Outputs decode from state only: Idle=(IDLE), Done=(DONE).
- IDLE, St=1 at the edge, Divisor≠0:
  - R←0, Q←Dividend, D←Divisor, cnt←N, DivZero←0.
  - Next state SHIFT.
- IDLE, St=1 at the edge, Divisor=0:
  - DivZero←1, Q←all ones, R←Dividend (zero-extended).
  - Next state DONE; no iterations are run.
- IDLE, St=0: hold all registers.
- SHIFT: {R,Q}←{R,Q}<<1, with the R MSB side receiving Q[N-1] and Q[0]←0. Next state SUB.
- SUB: trial difference T=R−{1'b0,D}, computed at N+1 bits.
  - If T is non-negative (T MSB=0): R←T, Q[0]←1. Otherwise R and Q are held.
  - cnt←cnt−1.
  - If cnt==1 before the decrement, next state is DONE; otherwise SHIFT.
- DONE: Done=1 for exactly one cycle. Next state IDLE unconditionally.
- Output mapping: Quotient=Q and Remainder=R[N-1:0] at all times. The values are stable and correct while Done=1 and through IDLE until the next start.
- Latency, counting the start edge as edge 1:
  - Normal division: Done is high after edge 2N+1 and Idle is high after edge 2N+2. For N=8 that is Done after edge 17, Idle after edge 18.
  - Divide by zero: Done after edge 1, Idle after edge 2.
- St while not in IDLE is ignored; in-flight operands are never re-captured.
- If St is held high continuously, a new division starts on the first edge in IDLE, giving back-to-back operation with one IDLE cycle between Done pulses.
- Operand inputs may change freely after the start edge.
- Arithmetic is unsigned only. Signed handling is done by the caller.
- Invariant on completion: Dividend = Quotient·Divisor + Remainder, with Remainder < Divisor.

Test Plan:
- Normal case (N=8): Dividend=100, Divisor=7, St pulsed 1 cycle → Done high after edge 17; Quotient=14, Remainder=2, DivZero=0; Idle=1 after edge 18.
- Edge values: 255/1 → Q=255, R=0. 5/9 → Q=0, R=5. 0/3 → Q=0, R=0. 255/255 → Q=1, R=0. Each completes in 17 edges.
- Divide by zero: 42/0 → Done after edge 1; DivZero=1, Q=255, R=42. Next start 10/3 → DivZero=0, Q=3, R=1.
- Reset mid-operation: start 200/3, assert Reset after edge 6 → next cycle Idle=1, Done=0, Q=R=0. A new start 200/3 then gives Q=66, R=2.
- Handshake:
  - Pulse St during SHIFT/SUB with different operands → result unaffected.
  - Hold St=1 across two operations (50/6 then 9/4, operands switched while busy) → two one-cycle Done pulses 18 edges apart, with Q/R=8/2 then 2/1.
- Random regression: 1000 random pairs including Divisor=0 → check Q·D+R=Dividend and R<D, or the zero-divisor rule, at every Done.
